// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read slave port between M masters, one burst in flight.
// Optional macro AXI_RD_ARB_LEN_CHECK_EN adds a sticky len_err output for RLAST/ARLEN disagreement.
module axi_rd_arbiter #(
  parameter int M          = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [M-1:0]             m_arvalid,
  output logic [M-1:0]             m_arready,
  input  logic [M*ID_WIDTH-1:0]    m_arid,
  input  logic [M*ADDR_WIDTH-1:0]  m_araddr,
  input  logic [M*4-1:0]           m_arlen,
  input  logic [M*3-1:0]           m_arsize,
  input  logic [M*2-1:0]           m_arburst,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  output logic [ID_WIDTH-1:0]      s_arid,
  output logic [ADDR_WIDTH-1:0]    s_araddr,
  output logic [3:0]               s_arlen,
  output logic [2:0]               s_arsize,
  output logic [1:0]               s_arburst,
  input  logic                     s_rvalid,
  output logic                     s_rready,
  input  logic [DATA_WIDTH-1:0]    s_rdata,
  input  logic [1:0]               s_rresp,
  input  logic                     s_rlast,
  input  logic [ID_WIDTH-1:0]      s_rid,
  output logic [M-1:0]             m_rvalid,
  input  logic [M-1:0]             m_rready,
  output logic [DATA_WIDTH-1:0]    m_rdata,
  output logic [1:0]               m_rresp,
  output logic                     m_rlast,
  output logic [ID_WIDTH-1:0]      m_rid,
  output logic [M-1:0]             grant,
  output logic                     busy
`ifdef AXI_RD_ARB_LEN_CHECK_EN
  ,
  output logic                     len_err
`endif
);

  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   gnt_idx, rr_ptr, win_idx, cand;
  logic               win_found;
  int                 idx_scan;
  logic [M-1:0]       grant_r;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [3:0]         ar_len;
  logic [2:0]         ar_size;
  logic [1:0]         ar_burst;
  logic               r_hs;

  // Round-robin search starting at rr_ptr; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_scan  = 0;
    cand      = '0;
    for (int k = 0; k < M; k++) begin
      idx_scan = (int'(rr_ptr) + k) % M;
      cand     = IDX_W'(idx_scan);
      if (!win_found && m_arvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Handshake outputs are held low while clr is asserted so a reset mid-burst accepts nothing.
  always_comb begin
    state_nxt = state;
    m_arready = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_rvalid  = '0;
    unique case (state)
      IDLE: begin
        if (!clr && win_found) begin
          m_arready[win_idx] = 1'b1;
          state_nxt          = ADDR;
        end
      end
      ADDR: begin
        s_arvalid = !clr;
        if (s_arready) state_nxt = DATA;
      end
      DATA: begin
        s_rready          = !clr && m_rready[gnt_idx];
        m_rvalid[gnt_idx] = !clr && s_rvalid;
        if (s_rvalid && s_rready && s_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign r_hs = (state == DATA) && s_rvalid && s_rready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      grant_r  <= '0;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_found) begin
        gnt_idx  <= win_idx;
        grant_r  <= {{(M-1){1'b0}}, 1'b1} << win_idx;
        ar_id    <= m_arid[win_idx*ID_WIDTH +: ID_WIDTH];
        ar_addr  <= m_araddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ar_len   <= m_arlen[win_idx*4 +: 4];
        ar_size  <= m_arsize[win_idx*3 +: 3];
        ar_burst <= m_arburst[win_idx*2 +: 2];
      end
      if (r_hs && s_rlast) begin
        grant_r <= '0;
        rr_ptr  <= (gnt_idx == IDX_W'(M-1)) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  end

`ifdef AXI_RD_ARB_LEN_CHECK_EN
  logic [4:0] beat_cnt;
  logic       len_err_r;

  // A beat is wrong exactly when RLAST disagrees with "this is beat number ARLEN".
  always_ff @(posedge clk) begin
    if (clr) begin
      beat_cnt  <= '0;
      len_err_r <= 1'b0;
    end else if (state == ADDR && s_arready) begin
      beat_cnt <= '0;
    end else if (r_hs) begin
      beat_cnt <= beat_cnt + 5'd1;
      if (s_rlast != (beat_cnt == {1'b0, ar_len})) len_err_r <= 1'b1;
    end
  end

  assign len_err = len_err_r;
`endif

  assign s_arid    = ar_id;
  assign s_araddr  = ar_addr;
  assign s_arlen   = ar_len;
  assign s_arsize  = ar_size;
  assign s_arburst = ar_burst;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;
  assign m_rid     = s_rid;
  assign grant     = grant_r;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR requests and R beats are queued when driven
// and checked when the DUT presents them to the slave or a master.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  m_arvalid, m_arready;
  logic [1:0]  m_arid;
  logic [63:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [5:0]  m_arsize;
  logic [3:0]  m_arburst;
  logic        s_arvalid, s_arready;
  logic [0:0]  s_arid;
  logic [31:0] s_araddr;
  logic [3:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [0:0]  s_rid;
  logic [1:0]  m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [0:0]  m_rid;
  logic [1:0]  grant;
  logic        busy;
`ifdef AXI_RD_ARB_LEN_CHECK_EN
  logic        len_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        id;
  } ar_t;

  typedef struct {
    int          mst;
    logic [31:0] data;
    logic        last;
    logic        id;
  } beat_t;

  ar_t   ar_q[$];
  beat_t beat_q[$];

  axi_rd_arbiter #(.M(2), .ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .clr(clr),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .grant(grant), .busy(busy)
`ifdef AXI_RD_ARB_LEN_CHECK_EN
    , .len_err(len_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int m, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic id);
    ar_t e;
    m_araddr[m*32 +: 32] = addr;
    m_arlen[m*4 +: 4]    = len;
    m_arsize[m*3 +: 3]   = size;
    m_arburst[m*2 +: 2]  = burst;
    m_arid[m]            = id;
    m_arvalid[m]         = 1'b1;
    e.mst = m; e.addr = addr; e.len = len; e.size = size; e.burst = burst; e.id = id;
    ar_q.push_back(e);
  endtask

  // Called at posedge+1: expects master m accepted this cycle, then the slave AR one cycle later.
  task automatic serveGrant(input int m);
    @(negedge clk);
    checkOutput("arready_winner", 32'(m_arready), 32'(1) << m);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
    @(negedge clk);
    checkOutput("ar_latency", 32'(s_arvalid), 1);
    checkOutput("arready_in_addr", 32'(m_arready), 0);
    @(posedge clk); #1;
  endtask

  // Drives beats 0..stop-1 of an n-beat burst; each expected beat is queued as it is driven.
  task automatic sendBurst(input int owner, input logic id, input int n, input int stop,
                           input logic [31:0] base, input bit toggle);
    beat_t b;
    bit    hs;
    int    cnt;
    for (int i = 0; i < stop; i++) begin
      s_rvalid = 1'b1;
      s_rdata  = base + 32'(i);
      s_rlast  = (i == n - 1);
      s_rid    = id;
      s_rresp  = 2'b00;
      b.mst = owner; b.data = base + 32'(i); b.last = (i == n - 1); b.id = id;
      beat_q.push_back(b);
      hs  = 1'b0;
      cnt = 0;
      while (!hs && cnt < 50) begin
        @(negedge clk);
        checkOutput("s_rready_mirror", 32'(s_rready), 32'(m_rready[owner]));
        checkOutput("m_rvalid_route", 32'(m_rvalid), 32'(s_rvalid) << owner);
        hs = s_rvalid && s_rready;
        @(posedge clk); #1;
        cnt++;
        if (toggle) m_rready[0] = ~m_rready[0];
      end
      if (!hs) checkOutput("beat_timeout", 0, 1);
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  // Scoreboard monitors, sampled on the falling edge between drive and commit.
  always @(negedge clk) begin
    ar_t   ea;
    beat_t eb;
    checkOutput("arready_onehot0", 32'($onehot0(m_arready)), 1);
    checkOutput("rvalid_onehot0", 32'($onehot0(m_rvalid)), 1);
    if (s_arvalid && s_arready) begin
      if (ar_q.size() == 0) checkOutput("ar_unexpected", 1, 0);
      else begin
        ea = ar_q.pop_front();
        checkOutput("s_araddr", s_araddr, ea.addr);
        checkOutput("s_arlen", 32'(s_arlen), 32'(ea.len));
        checkOutput("s_arsize", 32'(s_arsize), 32'(ea.size));
        checkOutput("s_arburst", 32'(s_arburst), 32'(ea.burst));
        checkOutput("s_arid", 32'(s_arid), 32'(ea.id));
        checkOutput("grant_owner", 32'(grant), 32'(1) << ea.mst);
      end
    end
    if ((m_rvalid & m_rready) != 2'b00) begin
      if (beat_q.size() == 0) checkOutput("beat_unexpected", 1, 0);
      else begin
        eb = beat_q.pop_front();
        checkOutput("m_rdata", m_rdata, eb.data);
        checkOutput("m_rlast", 32'(m_rlast), 32'(eb.last));
        checkOutput("m_rid", 32'(m_rid), 32'(eb.id));
        checkOutput("m_rresp", 32'(m_rresp), 0);
        checkOutput("m_rvalid_owner", 32'(m_rvalid), 32'(1) << eb.mst);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clr = 1'b1;
    m_arvalid = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0;
    m_rready = 2'b11;

    // Reset held with both masters requesting; afterwards m0 must win from rr_ptr=0.
    applyStimulus(0, 32'h10, 4'd1, 3'd2, 2'd1, 1'b0);
    applyStimulus(1, 32'h08, 4'd2, 3'd2, 2'd1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_arready", 32'(m_arready), 0);
    checkOutput("rst_s_arvalid", 32'(s_arvalid), 0);
    checkOutput("rst_m_rvalid", 32'(m_rvalid), 0);
    checkOutput("rst_s_rready", 32'(s_rready), 0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Simultaneous m0/m1, then m0 re-requests: order must be m0, m1, m0.
    serveGrant(0);
    applyStimulus(0, 32'h30, 4'd0, 3'd1, 2'd1, 1'b0);
    sendBurst(0, 1'b0, 2, 2, 32'hB0, 1'b0);
    serveGrant(1);
    sendBurst(1, 1'b1, 3, 3, 32'hC0, 1'b0);
    serveGrant(0);
    sendBurst(0, 1'b0, 1, 1, 32'hD0, 1'b0);
    checkOutput("fair_ar_q_empty", 32'(ar_q.size()), 0);

    // Single request, four beats.
    applyStimulus(0, 32'h00, 4'd3, 3'd1, 2'd1, 1'b0);
    serveGrant(0);
    sendBurst(0, 1'b0, 4, 4, 32'hA0, 1'b0);
    @(negedge clk);
    checkOutput("single_busy_after", 32'(busy), 0);
    checkOutput("single_grant_after", 32'(grant), 0);
    checkOutput("single_beat_q_empty", 32'(beat_q.size()), 0);
    @(posedge clk); #1;

    // Backpressure on AR for three cycles, then a toggling master ready.
    s_arready = 1'b0;
    applyStimulus(0, 32'h40, 4'd3, 3'd2, 2'd1, 1'b1);
    @(negedge clk);
    checkOutput("bp_arready", 32'(m_arready), 32'h1);
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_s_arvalid", 32'(s_arvalid), 1);
      checkOutput("bp_s_araddr", s_araddr, 32'h40);
      checkOutput("bp_s_arlen", 32'(s_arlen), 3);
      @(posedge clk); #1;
    end
    s_arready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    m_rready[0] = 1'b0;
    sendBurst(0, 1'b1, 4, 4, 32'hE0, 1'b1);
    m_rready = 2'b11;
    checkOutput("bp_beat_q_empty", 32'(beat_q.size()), 0);

    // Reset after two of four beats, then a fresh request from m1.
    applyStimulus(0, 32'h50, 4'd3, 3'd1, 2'd1, 1'b0);
    serveGrant(0);
    sendBurst(0, 1'b0, 4, 2, 32'h90, 1'b0);
    s_rvalid = 1'b1;
    s_rdata  = 32'h92;
    clr      = 1'b1;
    @(negedge clk);
    checkOutput("midrst_s_rready", 32'(s_rready), 0);
    checkOutput("midrst_m_rvalid", 32'(m_rvalid), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    checkOutput("postrst_busy", 32'(busy), 0);
    checkOutput("postrst_s_rready", 32'(s_rready), 0);
    checkOutput("postrst_grant", 32'(grant), 0);
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    applyStimulus(1, 32'h60, 4'd1, 3'd1, 2'd1, 1'b1);
    serveGrant(1);
    sendBurst(1, 1'b1, 2, 2, 32'h70, 1'b0);
    checkOutput("postrst_beat_q_empty", 32'(beat_q.size()), 0);

`ifdef AXI_RD_ARB_LEN_CHECK_EN
    // ARLEN=2 but RLAST on the second beat must latch len_err until clr.
    @(negedge clk);
    checkOutput("len_err_clear", 32'(len_err), 0);
    @(posedge clk); #1;
    applyStimulus(0, 32'h80, 4'd2, 3'd2, 2'd1, 1'b0);
    serveGrant(0);
    sendBurst(0, 1'b0, 2, 2, 32'h11, 1'b0);
    @(negedge clk);
    checkOutput("len_err_set", 32'(len_err), 1);
    @(posedge clk); #1;
    applyStimulus(1, 32'h84, 4'd0, 3'd2, 2'd1, 1'b1);
    serveGrant(1);
    sendBurst(1, 1'b1, 1, 1, 32'h22, 1'b0);
    @(negedge clk);
    checkOutput("len_err_sticky", 32'(len_err), 1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    checkOutput("len_err_cleared", 32'(len_err), 0);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one slave read port (AR + R channels) between M masters.
- Round-robin grant; one outstanding read burst at a time.
- Granted master's AR fields are registered and replayed to the slave. R beats are routed back to that master until the RLAST handshake.
- Sits between the masters' read-request FIFOs and a slave Memory read port inside top.

Parameters:
M, 2, number of requesting masters (2..8)
ID_WIDTH, 1, ARID/RID width
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, read data width

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous reset, active-high
m_arvalid  in  M  per-master read request valid
m_arready  out  M  per-master request accept (one-hot or zero)
m_arid  in  M*ID_WIDTH  packed ARID, master i at [i*ID_WIDTH +: ID_WIDTH]
m_araddr  in  M*ADDR_WIDTH  packed ARADDR
m_arlen  in  M*4  packed ARLEN (beats-1)
m_arsize  in  M*3  packed ARSIZE
m_arburst  in  M*2  packed ARBURST
s_arvalid  out  1  slave request valid
s_arready  in  1  slave request ready
s_arid  out  ID_WIDTH  registered ARID
s_araddr  out  ADDR_WIDTH  registered ARADDR
s_arlen  out  4  registered ARLEN
s_arsize  out  3  registered ARSIZE
s_arburst  out  2  registered ARBURST
s_rvalid  in  1  slave read data valid
s_rready  out  1  slave read data ready
s_rdata  in  DATA_WIDTH  read data
s_rresp  in  2  read response
s_rlast  in  1  last beat
s_rid  in  ID_WIDTH  read ID
m_rvalid  out  M  per-master read valid (one-hot or zero)
m_rready  in  M  per-master read ready
m_rdata  out  DATA_WIDTH  s_rdata passthrough, shared
m_rresp  out  2  s_rresp passthrough
m_rlast  out  1  s_rlast passthrough
m_rid  out  ID_WIDTH  s_rid passthrough
grant  out  M  registered one-hot owner, zero in IDLE
busy  out  1  high when state != IDLE

Behaviour:
- State machine: IDLE -> ADDR -> DATA -> IDLE. Register state, gnt_idx, rr_ptr (clog2(M) bits), AR field latch, beat_cnt (5 bits).
- Reset (clr=1 at posedge):
  - state=IDLE, rr_ptr=0, grant=0, busy=0, beat_cnt=0.
  - s_arvalid=0, m_arready=0, m_rvalid=0, s_rready=0; latched AR fields=0.
  - Reset mid-burst abandons the transaction; remaining slave beats are not accepted.
- IDLE:
  - Winner = first i with m_arvalid[i], scanning rr_ptr, rr_ptr+1, ... mod M.
  - m_arready[winner]=1 combinationally in that cycle.
  - On that posedge: latch the winner's fields, gnt_idx=winner, state=ADDR.
  - No valid request: stay in IDLE, all m_arready=0.
- ADDR:
  - s_arvalid=1 with latched fields, stable until s_arready.
  - On s_arvalid&s_arready: state=DATA, beat_cnt=0.
  - Minimum latency from request accept to s_arvalid is 1 cycle.
- DATA:
  - s_rready=m_rready[gnt_idx]; m_rvalid[gnt_idx]=s_rvalid; all other m_rvalid=0.
  - m_rdata/m_rresp/m_rlast/m_rid are combinational passthroughs.
  - Each s_rvalid&s_rready: beat_cnt+1.
  - Handshake with s_rlast=1: state=IDLE, rr_ptr=(gnt_idx+1) mod M.
  - The next grant can occur the cycle after returning to IDLE (at least 1 idle cycle between bursts).
- m_arready is 0 in ADDR and DATA; requests arriving then wait.
- s_rvalid in IDLE/ADDR is ignored: s_rready=0, nothing forwarded.
- Only one m_arready/m_rvalid bit may ever be high.
- Simultaneous requests: round-robin order, starting from rr_ptr.

Optional Feature:
- Macro AXI_RD_ARB_LEN_CHECK_EN.
- Defined: extra output len_err (1 bit), sticky, cleared only by clr.
- len_err sets when RLAST handshakes with beat_cnt != latched arlen.
- len_err also sets when a handshake at beat_cnt == arlen lacks RLAST; that beat still forwards and the state stays DATA.
- Undefined: no len_err port, no comparison logic; beat_cnt may be omitted.

Test Plan:
- Reset: hold clr=1 for 2 cycles with requests active -> all valids/readies/grant 0, busy 0; first grant goes to master 0.
- Single request: m0 araddr=0x00, arlen=3, arsize=1; slave returns 4 beats 0xA0..0xA3 with RLAST on the 4th -> s_araddr=0x00 one cycle after accept; m_rvalid[0] carries 4 beats; state IDLE after the last; grant[1]-side bits never set.
- Simultaneous m0 and m1 requests (m1 araddr=0x08, arlen=2) -> m0 served first, m1 granted the cycle after m0's RLAST; third back-to-back m0 request is served only after m1 (fairness).
- Backpressure: s_arready low 3 cycles, then m_rready[0] toggling -> s_ar* stable; s_rready mirrors m_rready[0]; no beat lost or duplicated.
- Reset mid-DATA after 2 of 4 beats -> IDLE next cycle, s_rready=0, new request accepted normally.
- With AXI_RD_ARB_LEN_CHECK_EN: arlen=2 but RLAST on beat 2 -> len_err=1 and stays 1 until clr.
